reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-back stage directly upstream of the 8-entry register file.
- Merges ALU results (available immediately) and data-memory load returns (LD_LAT cycles after issue) into the register file's single registered write port (wr_en / wr_addr / dat_in).
- Arbitrates collisions between the two sources and tracks in-flight loads on a per-register scoreboard.
- Supplies bypassed read operands and load-use hazard flags to the decode/execute stage.

Parameters:
- pw, 3: register address width; 2**pw registers.
- LD_LAT, 1: cycles from ld_issue to mem_dat valid; legal range 1..4.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result presented this cycle.
- alu_dest  in  pw  ALU destination register.
- alu_result  in  8  ALU result data.
- ld_issue  in  1  load issued to data memory this cycle.
- ld_dest  in  pw  load destination register.
- mem_dat  in  8  data-memory read data; valid exactly LD_LAT cycles after ld_issue.
- rd_addrA, rd_addrB  in  pw  operand addresses, same values driven to the register file.
- rf_datA, rf_datB  in  8  register file combinational read data.
- wr_en  out  1  register file write enable.
- wr_addr  out  pw  register file write address.
- dat_in  out  8  register file write data.
- opA, opB  out  8  bypassed operands.
- hazA, hazB  out  1  operand has a load still in flight; consumer must stall.
- stall  out  1  hold buffer occupied; upstream must not present alu_valid.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (synchronous, active-high):
  - wr_en=0, wr_addr=0, dat_in=0, proto_err=0.
  - Hold buffer empty, scoreboard cleared, load tag pipe cleared.
  - Loads in flight at reset are discarded; mem_dat is ignored until a new ld_issue.
- Output register (wr_en/wr_addr/dat_in) is loaded every edge; wr_en=0 when no source is selected. The register file commits at the following edge.
- ALU path:
  - alu_valid at cycle t, no conflict -> wr_en=1 during cycle t+1.
- Load path:
  - ld_issue at cycle t pushes {valid, ld_dest} into an LD_LAT-deep tag pipe.
  - When the tag emerges at cycle t+LD_LAT, mem_dat is sampled -> wr_en=1 during cycle t+LD_LAT+1.
- Source priority at each edge: load return > hold buffer > alu_valid.
  - Load return with alu_valid: ALU result goes into the hold buffer.
  - Load return with hold full: hold is retained.
  - Hold full, no load return: hold drains to the output register. A simultaneous alu_valid (a contract violation) is ignored and sets proto_err.
- stall = hold_valid (combinational).
- Scoreboard pend[2**pw]:
  - Set at ld_issue.
  - Cleared at the edge the load result enters the output register.
  - Set and clear on the same register at the same edge: set wins.
- hazA = pend[rd_addrA]; hazB likewise. Both are combinational.
- Bypass priority for opA (opB identical): hold buffer dest match > output register (wr_en & wr_addr match) > rf_datA.
- proto_err is set (sticky until reset) on any of:
  - alu_valid while stall=1;
  - ld_issue to a register with pend set;
  - alu_valid with alu_dest pend set (WAW against an in-flight load).
- Arithmetic: data is passed through unmodified, 8 bits, no width conversion.

Decomposition:
- Package wb_pkg holds:
  - constants PW=3, DW=8, LD_LAT_MAX=4;
  - typedef wb_src_e {WB_NONE, WB_LOAD, WB_HOLD, WB_ALU} for the write-source mux select;
  - struct ld_tag_t {valid, dest}.
- One natural sub-module: ld_tag_pipe, a parameterised LD_LAT-stage shift of ld_tag_t with synchronous clear.

Test Plan:
- Reset; alu_valid=1, alu_dest=3, alu_result=8'h5A at cycle 2 -> wr_en=1, wr_addr=3, dat_in=8'h5A in cycle 3; register 3 reads 8'h5A from cycle 4.
- LD_LAT=1: ld_issue dest=5 at cycle 2, mem_dat=8'hC3 at cycle 3 -> hazA=1 for rd_addrA=5 in cycle 3; write in cycle 4 with opA=8'hC3 bypassed; hazA=0 from cycle 4.
- Collision: ld_issue dest=1 at t, alu_valid dest=2 data=8'h11 at t+1, mem_dat=8'h22 -> t+2 writes r1=8'h22 with stall=1; t+3 writes r2=8'h11 with stall=0.
- WAW bypass: hold has r4=8'hAA while the output register writes r4=8'hBB -> opA (rd_addrA=4) = 8'hAA; final r4 = 8'hAA.
- Reset mid-load: ld_issue dest=6, reset asserted the next cycle, mem_dat arrives -> no write to r6, pend[6]=0, wr_en=0.
- Protocol errors: alu_valid while stall=1 -> proto_err=1, held ALU value still written; a second ld_issue to pending r5 -> proto_err stays 1 until reset.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register write-back stage.
package wb_pkg;

  localparam int unsigned PW         = 3;
  localparam int unsigned DW         = 8;
  localparam int unsigned LD_LAT_MAX = 4;

  // Selects which source loads the register-file write port this edge.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_LOAD,
    WB_HOLD,
    WB_ALU
  } wb_src_e;

  // Destination tag that travels alongside an outstanding load.
  typedef struct packed {
    logic          valid;
    logic [PW-1:0] dest;
  } ld_tag_t;

endpackage

// File: rtl/ld_tag_pipe.sv
// Fixed-latency shift of load tags; the tag pops out the cycle mem_dat is valid.
module ld_tag_pipe
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  ld_tag_t i_tag,
  output ld_tag_t o_tag
);

  ld_tag_t r_stage [Depth];

  // Shift tags one stage per cycle; reset drops every in-flight load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < Depth; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[Depth-1];

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: merges ALU results and load returns into the single
// register-file write port, tracks in-flight loads, and bypasses operands.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int unsigned pw     = PW,
  parameter int unsigned LD_LAT = 1  // legal range 1..LD_LAT_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [pw-1:0] alu_dest,
  input  logic [DW-1:0] alu_result,
  input  logic          ld_issue,
  input  logic [pw-1:0] ld_dest,
  input  logic [DW-1:0] mem_dat,
  input  logic [pw-1:0] rd_addrA,
  input  logic [pw-1:0] rd_addrB,
  input  logic [DW-1:0] rf_datA,
  input  logic [DW-1:0] rf_datB,
  output logic          wr_en,
  output logic [pw-1:0] wr_addr,
  output logic [DW-1:0] dat_in,
  output logic [DW-1:0] opA,
  output logic [DW-1:0] opB,
  output logic          hazA,
  output logic          hazB,
  output logic          stall,
  output logic          proto_err
);

  localparam int unsigned NReg = 1 << pw;

  logic            r_wr_en;
  logic [pw-1:0]   r_wr_addr;
  logic [DW-1:0]   r_dat;
  logic            r_hold_valid;
  logic [pw-1:0]   r_hold_dest;
  logic [DW-1:0]   r_hold_dat;
  logic [NReg-1:0] r_pend;
  logic            r_proto_err;

  ld_tag_t         w_tag_in;
  ld_tag_t         w_tag_out;
  wb_src_e         w_src;
  logic            w_alu_to_hold;
  logic [NReg-1:0] w_pend_nxt;
  logic            w_err;

  ld_tag_pipe #(
    .Depth (LD_LAT)
  ) u_ld_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Tag pushed for every issued load.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = ld_issue;
    w_tag_in.dest  = ld_dest;
  end

  // Write-source arbitration: load return > hold buffer > ALU.
  always_comb begin
    w_src         = WB_NONE;
    w_alu_to_hold = 1'b0;
    if (w_tag_out.valid) begin
      w_src         = WB_LOAD;
      // A full hold buffer is kept; an ALU result then is a protocol violation.
      w_alu_to_hold = alu_valid & ~r_hold_valid;
    end else if (r_hold_valid) begin
      w_src = WB_HOLD;
    end else if (alu_valid) begin
      w_src = WB_ALU;
    end
  end

  // Output register, reloaded every edge; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_dat     <= '0;
    end else begin
      unique case (w_src)
        WB_LOAD: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_tag_out.dest;
          r_dat     <= mem_dat;
        end
        WB_HOLD: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_hold_dest;
          r_dat     <= r_hold_dat;
        end
        WB_ALU: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= alu_dest;
          r_dat     <= alu_result;
        end
        WB_NONE: r_wr_en <= 1'b0;
      endcase
    end
  end

  // Hold buffer parks an ALU result displaced by a load return.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_dest  <= '0;
      r_hold_dat   <= '0;
    end else if (w_alu_to_hold) begin
      r_hold_valid <= 1'b1;
      r_hold_dest  <= alu_dest;
      r_hold_dat   <= alu_result;
    end else if (w_src == WB_HOLD) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Scoreboard next state: clear on load return, then set on issue so set wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_tag_out.valid) w_pend_nxt[w_tag_out.dest] = 1'b0;
    if (ld_issue) w_pend_nxt[ld_dest] = 1'b1;
  end

  // Pending-load scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  assign w_err = (alu_valid & r_hold_valid) |
                 (ld_issue & r_pend[ld_dest]) |
                 (alu_valid & r_pend[alu_dest]);

  // Sticky protocol-violation flag.
  always_ff @(posedge clk) begin
    if (reset)      r_proto_err <= 1'b0;
    else if (w_err) r_proto_err <= 1'b1;
  end

  // Operand bypass: hold buffer is younger than the output register.
  always_comb begin
    opA = rf_datA;
    if (r_hold_valid && (r_hold_dest == rd_addrA))  opA = r_hold_dat;
    else if (r_wr_en && (r_wr_addr == rd_addrA))    opA = r_dat;
    opB = rf_datB;
    if (r_hold_valid && (r_hold_dest == rd_addrB))  opB = r_hold_dat;
    else if (r_wr_en && (r_wr_addr == rd_addrB))    opB = r_dat;
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign dat_in    = r_dat;
  assign hazA      = r_pend[rd_addrA];
  assign hazB      = r_pend[rd_addrB];
  assign stall     = r_hold_valid;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback (LD_LAT=1) with a register-file model and
// a queue of expected write-port transactions.
module tb_reg_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid;
  logic [2:0] alu_dest;
  logic [7:0] alu_result;
  logic       ld_issue;
  logic [2:0] ld_dest;
  logic [7:0] mem_dat;
  logic [2:0] rd_addrA;
  logic [2:0] rd_addrB;
  logic [7:0] rf_datA;
  logic [7:0] rf_datB;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] dat_in;
  logic [7:0] opA;
  logic [7:0] opB;
  logic       hazA;
  logic       hazB;
  logic       stall;
  logic       proto_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] rf [8] = '{default: 8'h00};

  always #5 clk = ~clk;

  reg_writeback #(
    .pw     (3),
    .LD_LAT (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_dest   (alu_dest),
    .alu_result (alu_result),
    .ld_issue   (ld_issue),
    .ld_dest    (ld_dest),
    .mem_dat    (mem_dat),
    .rd_addrA   (rd_addrA),
    .rd_addrB   (rd_addrB),
    .rf_datA    (rf_datA),
    .rf_datB    (rf_datB),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .dat_in     (dat_in),
    .opA        (opA),
    .opB        (opB),
    .hazA       (hazA),
    .hazB       (hazB),
    .stall      (stall),
    .proto_err  (proto_err)
  );

  // Register file model: commits the write port at the following edge.
  always @(posedge clk) if (wr_en === 1'b1) rf[wr_addr] <= dat_in;
  assign rf_datA = rf[rd_addrA];
  assign rf_datB = rf[rd_addrB];

  // Every write-port transaction must match the next expected one, in order.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t got;
      wr_t want;
      got = {wr_addr, dat_in};
      n_vec++;
      if (exp_q.size() == 0) begin
        assert (wr_en === 1'b0) else begin
          n_err++;
          $error("FAIL unexpected_write observed=%0h expected=none", got);
        end
      end else begin
        want = exp_q.pop_front();
        assert (got === want) else begin
          n_err++;
          $error("FAIL write_port observed=%0h expected=%0h", got, want);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    ld_issue  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_dest = '0; alu_result = '0;
    ld_issue = 1'b0; ld_dest = '0; mem_dat = '0; rd_addrA = '0; rd_addrB = '0;
    @(posedge clk); #1;
    smp();
    chk("rst_wr_en", wr_en, 0); chk("rst_wr_addr", wr_addr, 0);
    chk("rst_dat_in", dat_in, 0); chk("rst_proto", proto_err, 0); chk("rst_stall", stall, 0);
    nxt();
    reset = 1'b0;

    // ALU write: visible on the port next cycle, in the register file after.
    alu_valid = 1'b1; alu_dest = 3'd3; alu_result = 8'h5A; exp_q.push_back({3'd3, 8'h5A});
    smp(); chk("alu_stall", stall, 0); nxt();
    rd_addrA = 3'd3;
    smp(); chk("alu_wr_en", wr_en, 1); chk("alu_wr_addr", wr_addr, 3);
    chk("alu_dat_in", dat_in, 8'h5A); chk("alu_byp_out", opA, 8'h5A); nxt();
    smp(); chk("alu_idle", wr_en, 0); chk("alu_rf_read", opA, 8'h5A); nxt();

    // Load with hazard window.
    ld_issue = 1'b1; ld_dest = 3'd5; rd_addrA = 3'd5;
    smp(); chk("ld_haz_issue", hazA, 0); nxt();
    mem_dat = 8'hC3; exp_q.push_back({3'd5, 8'hC3});
    smp(); chk("ld_haz_flight", hazA, 1); nxt();
    rd_addrB = 3'd5;
    smp(); chk("ld_wr_en", wr_en, 1); chk("ld_opA", opA, 8'hC3); chk("ld_opB", opB, 8'hC3);
    chk("ld_hazA_clr", hazA, 0); chk("ld_hazB_clr", hazB, 0); nxt();

    // Collision: load return wins, ALU result parked in hold.
    ld_issue = 1'b1; ld_dest = 3'd1; smp(); nxt();
    alu_valid = 1'b1; alu_dest = 3'd2; alu_result = 8'h11; mem_dat = 8'h22;
    exp_q.push_back({3'd1, 8'h22}); exp_q.push_back({3'd2, 8'h11});
    smp(); chk("col_stall0", stall, 0); nxt();
    rd_addrB = 3'd2;
    smp(); chk("col_stall1", stall, 1); chk("col_wr_addr1", wr_addr, 1);
    chk("col_dat1", dat_in, 8'h22); chk("col_opB_hold", opB, 8'h11); nxt();
    smp(); chk("col_stall2", stall, 0); chk("col_wr_addr2", wr_addr, 2);
    chk("col_dat2", dat_in, 8'h11); chk("col_proto", proto_err, 0); nxt();

    // WAW: hold (younger) r4=AA beats the output register r4=BB.
    ld_issue = 1'b1; ld_dest = 3'd4; smp(); nxt();
    mem_dat = 8'hBB; alu_valid = 1'b1; alu_dest = 3'd4; alu_result = 8'hAA;
    exp_q.push_back({3'd4, 8'hBB}); exp_q.push_back({3'd4, 8'hAA});
    smp(); nxt();
    rd_addrA = 3'd4;
    smp(); chk("waw_opA_hold", opA, 8'hAA); chk("waw_dat", dat_in, 8'hBB);
    chk("waw_proto", proto_err, 1); nxt();
    smp(); chk("waw_dat2", dat_in, 8'hAA); chk("waw_opA_out", opA, 8'hAA); nxt();
    smp(); chk("waw_idle", wr_en, 0); chk("waw_rf_final", opA, 8'hAA); nxt();
    reset = 1'b1; smp(); nxt();
    reset = 1'b0;
    smp(); chk("waw_proto_rst", proto_err, 0); chk("waw_stall_rst", stall, 0); nxt();

    // Reset while a load is in flight: its return is discarded.
    ld_issue = 1'b1; ld_dest = 3'd6; rd_addrA = 3'd6; smp(); nxt();
    reset = 1'b1; mem_dat = 8'h77;
    smp(); chk("rml_haz_pre", hazA, 1); nxt();
    reset = 1'b0;
    smp(); chk("rml_wr_en", wr_en, 0); chk("rml_haz_post", hazA, 0); nxt();
    smp(); chk("rml_wr_en2", wr_en, 0); nxt();

    // ALU presented while stalled: ignored, flagged, held value still written.
    ld_issue = 1'b1; ld_dest = 3'd5; smp(); nxt();
    mem_dat = 8'h33; alu_valid = 1'b1; alu_dest = 3'd0; alu_result = 8'h44;
    exp_q.push_back({3'd5, 8'h33}); exp_q.push_back({3'd0, 8'h44});
    smp(); chk("pe_proto0", proto_err, 0); nxt();
    alu_valid = 1'b1; alu_dest = 3'd7; alu_result = 8'h99; rd_addrA = 3'd0;
    smp(); chk("pe_stall", stall, 1); chk("pe_proto1", proto_err, 0);
    chk("pe_opA_hold", opA, 8'h44); nxt();
    smp(); chk("pe_proto2", proto_err, 1); chk("pe_wr_addr", wr_addr, 0);
    chk("pe_dat", dat_in, 8'h44); chk("pe_stall_clr", stall, 0); nxt();
    reset = 1'b1; smp(); nxt();
    reset = 1'b0;
    smp(); chk("pe_proto_rst", proto_err, 0); nxt();

    // Second issue to a pending register; set beats the same-edge clear.
    ld_issue = 1'b1; ld_dest = 3'd5; rd_addrA = 3'd5; smp(); nxt();
    ld_issue = 1'b1; ld_dest = 3'd5; mem_dat = 8'h55; exp_q.push_back({3'd5, 8'h55});
    smp(); chk("dbl_proto0", proto_err, 0); chk("dbl_haz0", hazA, 1); nxt();
    mem_dat = 8'h66; exp_q.push_back({3'd5, 8'h66});
    smp(); chk("dbl_proto1", proto_err, 1); chk("dbl_haz_setwins", hazA, 1); nxt();
    smp(); chk("dbl_proto2", proto_err, 1); chk("dbl_haz_clr", hazA, 0); nxt();
    smp(); chk("dbl_proto3", proto_err, 1); nxt();
    reset = 1'b1; smp(); nxt();
    reset = 1'b0;
    smp(); chk("dbl_proto_rst", proto_err, 0); nxt();

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
